vc_id_decoder: RTL and testbench
================================

VC_ID_DECODER -- requirements
Module: vc_id_decoder

Interface
REQ-001 The block SHALL have parameter lenght_in, default 6: width of the binary id input.
REQ-002 The block SHALL have parameter lenght_out, default 64: width of the one-hot output; legal only if lenght_out <= 2**lenght_in.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-004 The block SHALL have port id_in  input  lenght_in  binary identifier to decode.
REQ-005 The block SHALL have port id_valid  input  1  id_in is valid this cycle.
REQ-006 The block SHALL have port id_ready  output  1  block accepts id_in this cycle.
REQ-007 The block SHALL have port vector_out  output  lenght_out  registered one-hot (or all-zero) decode of the head entry.
REQ-008 The block SHALL have port vector_valid  output  1  vector_out holds a valid entry.
REQ-009 The block SHALL have port vector_ready  input  1  consumer takes vector_out this cycle.
REQ-010 The block SHALL have port id_error  output  1  registered one-cycle pulse: an out-of-range id was accepted.
REQ-011 The block SHALL have port occupancy  output  2  number of stored entries (0..2).

Function
REQ-012 Handshakes SHALL be valid/ready: accept occurs when id_valid & id_ready; pop occurs when vector_valid & vector_ready.
REQ-013 Storage SHALL be a 2-entry FIFO of decoded vectors; states EMPTY (occupancy 0), ONE (1), FULL (2).
REQ-014 id_ready SHALL be a registered function of state: 1 in EMPTY and ONE, 0 in FULL; it SHALL NOT depend combinationally on vector_ready.
REQ-015 vector_valid SHALL be 1 exactly in ONE and FULL; vector_out SHALL be all-zero whenever vector_valid is 0.
REQ-016 Decode SHALL occur at accept: stored vector bit k = 1 iff id_in == k, for k in 0..lenght_out-1.
REQ-017 An id_in >= lenght_out SHALL be stored as an all-zero vector, still occupying an entry, and SHALL assert id_error in the next cycle for exactly one cycle.
REQ-018 Latency: an id accepted in cycle N into EMPTY SHALL appear on vector_out with vector_valid=1 in cycle N+1.
REQ-019 Transitions: EMPTY+accept -> ONE; ONE+accept-no-pop -> FULL; ONE+pop-no-accept -> EMPTY; ONE+accept+pop -> ONE, new entry at head in next cycle; FULL+pop -> ONE, second entry moves to head; otherwise state holds.
REQ-020 Order SHALL be strict FIFO; no entry SHALL be dropped, duplicated or reordered.
REQ-021 vector_out and vector_valid SHALL stay stable while vector_valid=1 and vector_ready=0.
REQ-022 id_valid while id_ready=0 SHALL be ignored with no state change.
REQ-023 Sustained id_valid=1 and vector_ready=1 SHALL yield one accept and one pop per cycle after the first (full throughput).

Reset
REQ-024 With rst=1 at a rising edge, the next cycle SHALL show state EMPTY, occupancy=0, vector_valid=0, vector_out=0, id_error=0, id_ready=1.
REQ-025 Reset mid-operation SHALL discard all stored entries and any pending id_error; an accept coincident with rst SHALL be discarded.

Verification
REQ-026 Reset, then id_in=5, id_valid=1 for one cycle, vector_ready=1 -> next cycle vector_out=64'h20, vector_valid=1, occupancy=1; following cycle vector_valid=0.
REQ-027 vector_ready=0; push 3, 7, 9 in consecutive cycles -> after two accepts occupancy=2, id_ready=0, id 9 not accepted; vector_ready=1 -> outputs bit 3 then bit 7, in order.
REQ-028 Out-of-range with lenght_out=48: push id 50 -> vector_out=0, vector_valid=1, id_error=1 for one cycle only.
REQ-029 Streaming ids 0..63 with id_valid=1 and vector_ready=1 -> 64 pops in 65 cycles, each vector one-hot at the matching bit.
REQ-030 Fill to FULL, assert rst for one cycle with id_valid=1 -> next cycle occupancy=0, vector_valid=0, id_ready=1; nothing later emitted.

Source files
------------

// File: rtl/vc_id_decoder.sv
// rtl/vc_id_decoder.sv - two-entry FIFO of one-hot decoded ids with valid/ready on both sides
// Ids at or above lenght_out are stored as all-zero vectors and flagged on id_error.
module vc_id_decoder #(
  parameter int lenght_in  = 6,
  parameter int lenght_out = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [lenght_in-1:0]  id_in,
  input  logic                  id_valid,
  output logic                  id_ready,
  output logic [lenght_out-1:0] vector_out,
  output logic                  vector_valid,
  input  logic                  vector_ready,
  output logic                  id_error,
  output logic [1:0]            occupancy
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t                r_state;
  logic [lenght_out-1:0] r_head;
  logic [lenght_out-1:0] r_tail;
  logic                  r_id_ready;
  logic                  r_vector_valid;
  logic                  r_id_error;
  logic [1:0]            r_occupancy;

  logic [lenght_out-1:0] w_decoded;
  logic [31:0]           w_id_wide;
  logic                  w_out_of_range;
  logic                  w_accept;
  logic                  w_pop;

  assign w_id_wide      = 32'(id_in);
  assign w_out_of_range = (w_id_wide >= 32'(lenght_out));
  assign w_accept       = id_valid & r_id_ready;
  assign w_pop          = r_vector_valid & vector_ready;

  always_comb begin
    w_decoded = '0;
    for (int k = 0; k < lenght_out; k++) begin
      w_decoded[k] = (w_id_wide == 32'(k));
    end
  end

  // Head is cleared whenever the FIFO drains so vector_out reads zero while invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_EMPTY;
      r_head         <= '0;
      r_tail         <= '0;
      r_id_ready     <= 1'b1;
      r_vector_valid <= 1'b0;
      r_occupancy    <= 2'd0;
      r_id_error     <= 1'b0;
    end else begin
      r_id_error <= w_accept & w_out_of_range;
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_head         <= w_decoded;
            r_state        <= S_ONE;
            r_vector_valid <= 1'b1;
            r_occupancy    <= 2'd1;
          end
        end
        S_ONE: begin
          if (w_accept && !w_pop) begin
            r_tail      <= w_decoded;
            r_state     <= S_FULL;
            r_id_ready  <= 1'b0;
            r_occupancy <= 2'd2;
          end else if (w_pop && !w_accept) begin
            r_head         <= '0;
            r_state        <= S_EMPTY;
            r_vector_valid <= 1'b0;
            r_occupancy    <= 2'd0;
          end else if (w_accept) begin
            r_head <= w_decoded;
          end
        end
        S_FULL: begin
          if (w_pop) begin
            r_head      <= r_tail;
            r_tail      <= '0;
            r_state     <= S_ONE;
            r_id_ready  <= 1'b1;
            r_occupancy <= 2'd1;
          end
        end
        default: begin
          r_state        <= S_EMPTY;
          r_head         <= '0;
          r_tail         <= '0;
          r_id_ready     <= 1'b1;
          r_vector_valid <= 1'b0;
          r_occupancy    <= 2'd0;
        end
      endcase
    end
  end

  assign id_ready     = r_id_ready;
  assign vector_out   = r_head;
  assign vector_valid = r_vector_valid;
  assign id_error     = r_id_error;
  assign occupancy    = r_occupancy;

endmodule

// File: tb/tb_vc_id_decoder.sv
// tb/tb_vc_id_decoder.sv - randomized and directed bench for vc_id_decoder against a queue model
module tb_vc_id_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic        vector_ready;
  logic [5:0]  id_in;

  logic        id_ready_a, vector_valid_a, id_error_a;
  logic [63:0] vector_out_a;
  logic [1:0]  occupancy_a;
  logic        id_ready_b, vector_valid_b, id_error_b;
  logic [47:0] vector_out_b;
  logic [1:0]  occupancy_b;

  int errors = 0;
  int checks = 0;
  int qa[$];
  int qb[$];
  bit erra = 1'b0;
  bit errb = 1'b0;
  int npops;

  always #5 clk = ~clk;

  vc_id_decoder #(.lenght_in(6), .lenght_out(64)) u_dut_a (
    .clk(clk), .rst(rst), .id_in(id_in), .id_valid(id_valid), .id_ready(id_ready_a),
    .vector_out(vector_out_a), .vector_valid(vector_valid_a), .vector_ready(vector_ready),
    .id_error(id_error_a), .occupancy(occupancy_a)
  );

  vc_id_decoder #(.lenght_in(6), .lenght_out(48)) u_dut_b (
    .clk(clk), .rst(rst), .id_in(id_in), .id_valid(id_valid), .id_ready(id_ready_b),
    .vector_out(vector_out_b), .vector_valid(vector_valid_b), .vector_ready(vector_ready),
    .id_error(id_error_b), .occupancy(occupancy_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] onehot(input int id, input int width);
    return (id < width) ? (64'd1 << id) : 64'd0;
  endfunction

  task automatic check_outputs();
    logic [63:0] exp_a;
    logic [63:0] exp_b;
    exp_a = 64'd0;
    exp_b = 64'd0;
    if (qa.size() > 0) exp_a = onehot(qa[0], 64);
    if (qb.size() > 0) exp_b = onehot(qb[0], 48);
    check("a_ready", 64'(id_ready_a), 64'(qa.size() < 2));
    check("a_valid", 64'(vector_valid_a), 64'(qa.size() > 0));
    check("a_vec", vector_out_a, exp_a);
    check("a_occ", 64'(occupancy_a), 64'(qa.size()));
    check("a_err", 64'(id_error_a), 64'(erra));
    check("b_ready", 64'(id_ready_b), 64'(qb.size() < 2));
    check("b_valid", 64'(vector_valid_b), 64'(qb.size() > 0));
    check("b_vec", 64'(vector_out_b), exp_b);
    check("b_occ", 64'(occupancy_b), 64'(qb.size()));
    check("b_err", 64'(id_error_b), 64'(errb));
  endtask

  // Behavioural model: each FIFO is a queue of raw ids holding at most two entries.
  task automatic model_step();
    bit acc_a, pop_a, acc_b, pop_b;
    acc_a = id_valid && (qa.size() < 2);
    pop_a = vector_ready && (qa.size() > 0);
    acc_b = id_valid && (qb.size() < 2);
    pop_b = vector_ready && (qb.size() > 0);
    if (rst) begin
      qa.delete();
      qb.delete();
      erra = 1'b0;
      errb = 1'b0;
    end else begin
      if (pop_a) void'(qa.pop_front());
      if (acc_a) qa.push_back(int'(id_in));
      erra = acc_a && (int'(id_in) >= 64);
      if (pop_b) void'(qb.pop_front());
      if (acc_b) qb.push_back(int'(id_in));
      errb = acc_b && (int'(id_in) >= 48);
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [5:0] id, input bit vr);
    rst          = r;
    id_valid     = v;
    id_in        = id;
    vector_ready = vr;
    if (!r && vector_valid_a && vr) npops++;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_in = '0; vector_ready = 1'b0;
    npops = 0;
    @(negedge clk);
    step(1, 0, 0, 0);

    // Single id through an empty FIFO
    step(0, 1, 6'd5, 1);
    check("r26_vec", vector_out_a, 64'h20);
    check("r26_occ", 64'(occupancy_a), 64'd1);
    step(0, 0, 0, 1);
    check("r26_drain", 64'(vector_valid_a), 64'd0);

    // Backpressure: third push is refused
    step(0, 1, 6'd3, 0);
    step(0, 1, 6'd7, 0);
    check("r27_occ", 64'(occupancy_a), 64'd2);
    check("r27_ready", 64'(id_ready_a), 64'd0);
    step(0, 1, 6'd9, 0);
    check("r27_hold", vector_out_a, 64'h8);
    step(0, 0, 0, 1);
    check("r27_second", vector_out_a, 64'h80);
    step(0, 0, 0, 1);
    check("r27_empty", 64'(occupancy_a), 64'd0);

    // Out-of-range id on the 48-wide instance
    step(0, 1, 6'd50, 0);
    check("r28_vec", 64'(vector_out_b), 64'd0);
    check("r28_valid", 64'(vector_valid_b), 64'd1);
    check("r28_err", 64'(id_error_b), 64'd1);
    step(0, 0, 0, 0);
    check("r28_err_pulse", 64'(id_error_b), 64'd0);
    step(0, 0, 0, 1);

    // Full-throughput streaming
    npops = 0;
    for (int i = 0; i < 64; i++) step(0, 1, 6'(i), 1);
    step(0, 0, 0, 1);
    check("r29_pops", 64'(npops), 64'd64);

    // Reset while full with a coincident push
    step(0, 1, 6'd1, 0);
    step(0, 1, 6'd2, 0);
    step(1, 1, 6'd4, 0);
    check("r30_occ", 64'(occupancy_a), 64'd0);
    check("r30_ready", 64'(id_ready_a), 64'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    check("r30_quiet", 64'(vector_valid_a), 64'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
           6'($urandom_range(0, 63)), $urandom_range(0, 2) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
